xmtbuf: RTL and testbench
=========================

# xmtbuf

Serial line transmitter buffer, the transmit counterpart of the UART receive buffer. Accepts one byte per write from the CPU I/O port and keeps it in a single-entry holding register. An internal shift transmitter sends it as an asynchronous 8N1 frame, or 8E1 when parity is compiled in. Double buffering lets the CPU queue the next byte while the current one is shifting, so back-to-back frames have no idle gap.

## Interface
- BAUD_DIV, 434: clock cycles per bit cell (50 MHz / 115200); legal range ≥ 2.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset; asserted while 0.
- write  in  1  single-cycle write strobe; accepted only when ready = 1.
- data_in  in  8  byte to transmit; sampled on an accepted write.
- ready  out  1  registered; 1 means the holding register is empty and can take a write.
- serial_out  out  1  registered TX line; idles at 1.

## Operation
- Holding register hold_data[7:0] with flag hold_full.
  - ready = ~hold_full, driven from a register.
- Accepted write (write & ready):
  - hold_data <= data_in, hold_full <= 1.
  - A write while ready = 0 is ignored; no overwrite and no error.
- Transfer: when hold_full = 1 and the transmitter can load, xmt takes hold_data and hold_full clears on the same edge.
  - Writes can only be accepted while hold_full = 0, so a write never coincides with a transfer.
- Transmitter can load when state is IDLE, or state is STOP with the baud counter at 0 (last cycle of the stop bit).
- xmt states:
  - IDLE: serial_out = 1.
  - START: serial_out = 0, one bit cell.
  - DATA: 8 cells, LSB first, bit index 0..7.
  - PARITY: only when parity is compiled in.
  - STOP: serial_out = 1, one bit cell.
- Transitions:
  - IDLE → START on load.
  - START → DATA at end of cell.
  - DATA → DATA until bit 7 ends, then PARITY (if compiled in) or STOP.
  - PARITY → STOP.
  - STOP → START if load, else IDLE.
- Baud counter: loads BAUD_DIV−1 on entry to each cell and counts down; the cell ends at 0. Width is $clog2(BAUD_DIV).
- Reset (reset = 0), at any time including mid-frame:
  - Frame is aborted; state IDLE.
  - hold_full = 0, ready = 1, serial_out = 1, counters = 0.
  - hold_data is don't-care.

## Timing
- Write accepted at edge N with xmt IDLE:
  - ready = 0 after edge N.
  - Load at edge N+1; ready = 1 and serial_out = 0 (start bit) after edge N+1.
- Write-to-start-bit latency: 2 cycles.
- Frame length: 10·BAUD_DIV cycles, or 11·BAUD_DIV with parity.
- Back-to-back: if hold_full is set before the last stop cycle, the next start bit follows the stop bit directly, with zero idle cycles.
- A second write is possible 1 cycle after the first is loaded. ready then stays 0 until the last cycle of the current frame.
- Reset takes effect at the first edge with reset = 0; outputs hold their reset values from the following cycle.

## Configuration
- XMTBUF_PARITY_EN defined:
  - Even-parity bit (XOR of the 8 data bits) is sent in a PARITY cell between bit 7 and STOP.
  - Frame is 11 cells.
- Undefined: no PARITY state exists; frame is 10 cells (8N1).

## Structure
- Shared package xmtbuf_pkg holds:
  - the xmt state enum (IDLE, START, DATA, PARITY, STOP);
  - DATA_BITS = 8;
  - localparam FRAME_CELLS, 10 or 11 depending on XMTBUF_PARITY_EN.
- Sub-module xmt is the shift transmitter: state machine, baud counter, shift register, and the can_load/load handshake.
- xmtbuf owns the holding register and the ready logic.

## Test plan
All scenarios use BAUD_DIV = 4.
- After reset = 0 for 2 cycles, then 1: serial_out = 1 and ready = 1. Nothing toggles for 100 cycles.
- Write 0x55 with xmt idle: ready = 0 for exactly 1 cycle. Start bit 2 cycles after the write; serial_out sequence per 4-cycle cell is 0,1,0,1,0,1,0,1,0,1; then idle.
- Write 0xA3, then write 0x0F as soon as ready = 1: the two frames are contiguous (no idle cell between the stop bit and the next start). Bits match LSB-first.
- Write 0x11 while ready = 0 during a full holding register: the byte is dropped, and only the first two queued bytes appear on the line.
- Pull reset low in DATA bit 3 of frame 0xFF: serial_out = 1 and ready = 1 the next cycle. A subsequent write of 0x80 produces a clean frame.
- With XMTBUF_PARITY_EN, write 0x07: parity cell = 1 and frame is 44 cycles. Write 0x03: parity cell = 0.

Source files
------------

// File: rtl/xmtbuf_pkg.sv
// Shared types and constants for the xmtbuf serial transmitter.
// Optional feature macro: XMTBUF_PARITY_EN (adds an even-parity cell, 8E1 framing).
package xmtbuf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef XMTBUF_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } xmt_state_t;

    localparam int DATA_BITS = 8;

`ifdef XMTBUF_PARITY_EN
    localparam int FRAME_CELLS = 11;
`else
    localparam int FRAME_CELLS = 10;
`endif

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/xmtbuf_xmt.sv
// Shift transmitter: start/data/(parity)/stop framing with a baud-cell down-counter.
// Optional feature macro: XMTBUF_PARITY_EN.
module xmtbuf_xmt
    import xmtbuf_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] data,
    output logic                 can_load,
    output logic                 serial_out
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CELL_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    xmt_state_t           state_r, state_s;
    logic [CW-1:0]        cnt_r, cnt_s;
    logic [2:0]           bit_r, bit_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic                 ser_r, ser_s;
`ifdef XMTBUF_PARITY_EN
    logic                 par_r, par_s;
`endif

    // Loading is allowed when idle or in the final cycle of the stop bit.
    assign can_load   = (state_r == ST_IDLE) ||
                        ((state_r == ST_STOP) && (cnt_r == CNT_ZERO));
    assign serial_out = ser_r;

    // Next-state, counter, shifter and line value.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        ser_s   = ser_r;
`ifdef XMTBUF_PARITY_EN
        par_s   = par_r;
`endif
        case (state_r)
            ST_IDLE: begin
                ser_s = 1'b1;
                if (load) begin
                    state_s = ST_START;
                    cnt_s   = CELL_LAST;
                    shift_s = data;
                    ser_s   = 1'b0;
`ifdef XMTBUF_PARITY_EN
                    par_s   = even_parity(data);
`endif
                end else begin
                    cnt_s = CNT_ZERO;
                end
            end
            ST_START: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_DATA;
                    cnt_s   = CELL_LAST;
                    bit_s   = 3'd0;
                    ser_s   = shift_r[0];
                    shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
                end else begin
                    cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_DATA: begin
                if (cnt_r == CNT_ZERO) begin
                    cnt_s = CELL_LAST;
                    if (bit_r == BIT_LAST) begin
`ifdef XMTBUF_PARITY_EN
                        state_s = ST_PARITY;
                        ser_s   = par_r;
`else
                        state_s = ST_STOP;
                        ser_s   = 1'b1;
`endif
                    end else begin
                        bit_s   = bit_r + 3'd1;
                        ser_s   = shift_r[0];
                        shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
                    end
                end else begin
                    cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end
            end
`ifdef XMTBUF_PARITY_EN
            ST_PARITY: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_STOP;
                    cnt_s   = CELL_LAST;
                    ser_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end
            end
`endif
            ST_STOP: begin
                if (cnt_r == CNT_ZERO) begin
                    // A queued byte starts immediately, giving gapless frames.
                    if (load) begin
                        state_s = ST_START;
                        cnt_s   = CELL_LAST;
                        shift_s = data;
                        ser_s   = 1'b0;
`ifdef XMTBUF_PARITY_EN
                        par_s   = even_parity(data);
`endif
                    end else begin
                        state_s = ST_IDLE;
                        ser_s   = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                ser_s   = 1'b1;
            end
        endcase
    end

    // Transmitter state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            bit_r   <= 3'd0;
            shift_r <= {DATA_BITS{1'b0}};
            ser_r   <= 1'b1;
`ifdef XMTBUF_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            ser_r   <= ser_s;
`ifdef XMTBUF_PARITY_EN
            par_r   <= par_s;
`endif
        end
    end

endmodule

// File: rtl/xmtbuf.sv
// Double-buffered serial transmitter: single-entry holding register feeding xmtbuf_xmt.
// Optional feature macro: XMTBUF_PARITY_EN (8E1 instead of 8N1).
module xmtbuf
    import xmtbuf_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 ready,
    output logic                 serial_out
);

    logic [DATA_BITS-1:0] hold_data_r;
    logic                 hold_full_r, hold_full_s;
    logic                 ready_r;
    logic                 can_load_s, load_s, accept_s;

    xmtbuf_xmt #(.BAUD_DIV(BAUD_DIV)) u_xmt (
        .clk        (clk),
        .reset      (reset),
        .load       (load_s),
        .data       (hold_data_r),
        .can_load   (can_load_s),
        .serial_out (serial_out)
    );

    // Accept and transfer never coincide: writes only land while the register is empty.
    always_comb begin
        load_s      = hold_full_r & can_load_s;
        accept_s    = write & ready_r;
        hold_full_s = hold_full_r;
        if (load_s) begin
            hold_full_s = 1'b0;
        end else if (accept_s) begin
            hold_full_s = 1'b1;
        end else begin
            hold_full_s = hold_full_r;
        end
    end

    // Holding-register flag and registered ready.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_full_r <= 1'b0;
            ready_r     <= 1'b1;
        end else begin
            hold_full_r <= hold_full_s;
            ready_r     <= ~hold_full_s;
        end
    end

    // Holding-register data; contents are irrelevant while empty, so no reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            hold_data_r <= data_in;
        end else begin
            hold_data_r <= hold_data_r;
        end
    end

    assign ready = ready_r;

endmodule

// File: tb/tb_xmtbuf.sv
// Self-checking bench for xmtbuf (BAUD_DIV = 4) against a frame-level line model.
module tb_xmtbuf;
    import xmtbuf_pkg::*;

    localparam int BD = 4;

    logic       clk;
    logic       reset;
    logic       write;
    logic [7:0] data_in;
    logic       ready;
    logic       serial_out;

    int checks   = 0;
    int failures = 0;

    // Expected line value after each upcoming clock edge.
    logic exp_q[$];
    // Edges remaining until the holding register empties (0 = ready).
    int   hold_left = 0;

    xmtbuf #(.BAUD_DIV(BD)) dut (
        .clk        (clk),
        .reset      (reset),
        .write      (write),
        .data_in    (data_in),
        .ready      (ready),
        .serial_out (serial_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    // A frame is start, 8 data bits LSB first, optional even parity, stop; each cell BD cycles.
    task automatic push_frame(input logic [7:0] b);
        logic cells[$];
        cells.push_back(1'b0);
        for (int i = 0; i < 8; i++) cells.push_back(b[i]);
`ifdef XMTBUF_PARITY_EN
        cells.push_back(^b);
`endif
        cells.push_back(1'b1);
        for (int c = 0; c < cells.size(); c++)
            for (int k = 0; k < BD; k++) exp_q.push_back(cells[c]);
    endtask

    task automatic do_cycle(input logic w, input logic [7:0] d);
        logic exp_s;
        int   l;
        if (w && hold_left == 0) begin
            if (exp_q.size() == 0) exp_q.push_back(1'b1);
            l = exp_q.size();
            push_frame(d);
            hold_left = l + 1;
        end
        write   = w;
        data_in = d;
        @(posedge clk); #1;
        write = 1'b0;
        if (hold_left > 0) hold_left--;
        exp_s = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
        check("serial_out", serial_out, exp_s);
        check("ready", ready, (hold_left == 0));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 8'h00);
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
        exp_q.delete();
        hold_left = 0;
        check("reset_serial_out", serial_out, 1'b1);
        check("reset_ready", ready, 1'b1);
        reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        write   = 1'b0;
        data_in = 8'h00;
        #1;

        // Power-on reset, then a quiet line.
        apply_reset(2);
        idle_cycles(100);

        // Single byte from idle: ready low one cycle, start bit two cycles after write.
        do_cycle(1'b1, 8'h55);
        check("ready_low_after_write", ready, 1'b0);
        idle_cycles(48);

        // Second write as soon as ready returns: contiguous frames.
        do_cycle(1'b1, 8'hA3);
        do_cycle(1'b0, 8'h00);
        check("ready_back_after_load", ready, 1'b1);
        do_cycle(1'b1, 8'h0F);
        idle_cycles(90);

        // Third byte while holding register is full is dropped.
        do_cycle(1'b1, 8'h3C);
        do_cycle(1'b0, 8'h00);
        do_cycle(1'b1, 8'hC3);
        idle_cycles(3);
        check("ready_low_when_full", ready, 1'b0);
        do_cycle(1'b1, 8'h11);
        idle_cycles(95);

        // Reset during data bit 3 of 0xFF, then a clean frame.
        do_cycle(1'b1, 8'hFF);
        idle_cycles(1 + BD + 3 * BD + 1);
        apply_reset(1);
        idle_cycles(5);
        do_cycle(1'b1, 8'h80);
        idle_cycles(50);

`ifdef XMTBUF_PARITY_EN
        do_cycle(1'b1, 8'h07);
        idle_cycles(50);
        do_cycle(1'b1, 8'h03);
        idle_cycles(50);
`endif

        // Random writes, including attempts while busy and back-to-back queueing.
        for (int i = 0; i < 1500; i++) begin
            do_cycle(($urandom_range(0, 11) == 0), 8'($urandom));
        end
        idle_cycles(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
